hrm_mmrx_rdsched: RTL and testbench
===================================

Name: hrm_mmrx_rdsched

Overview:
- Read scheduler for the hot-redundancy MCU receive buffer.
- On each scan request it does the following:
  - Opens the read channel with a chn_sel rising edge at hrm_pkt_num=0, which latches the ping-pong read bank.
  - Walks PKT_SLOTS fixed-size packet slots in the selected bank.
  - Streams every valid packet (SOP..EOP) to a downstream FIFO with sop/eop flags.
  - Closes the channel.
- Sits between the MMRX ping-pong buffer and the MCU-side packet FIFO. It replaces ad-hoc EMIF-driven reads.

Parameters:
- PKT_SLOTS, 4: packet slots per scan, max 16.
- SLOT_WORDS, 128: words per slot. Slot k base address = k*SLOT_WORDS. PKT_SLOTS*SLOT_WORDS must be ≤512.
- RD_LAT, 2: cycles from rd_addr to valid rd_data.

Ports:
- clk_100m  in  1  system clock.
- rst_100m  in  1  reset: synchronous, active-high.
- scan_start  in  1  one-cycle scan request.
- chn_sel  out  1  read channel select to the buffer; high for the whole scan.
- hrm_pkt_num  out  4  slot index currently read.
- rd_addr  out  9  buffer read address.
- rd_data  in  18  buffer read data. Bit17=SOP, bit16=EOP, [15:0] payload.
- out_dval  out  1  output word valid.
- out_data  out  18  output word, same format as rd_data.
- out_afull  in  1  downstream FIFO almost full. Threshold leaves ≥RD_LAT+1 free entries.
- scan_busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse at end of scan.
- pkt_cnt  out  5  packets delivered in the last completed scan.
- len_err  out  1  one-cycle pulse: a slot had no EOP within SLOT_WORDS.
- overrun_err  out  1  one-cycle pulse: scan_start arrived while busy.

Behaviour:
- Reset: state IDLE. All outputs 0: chn_sel, hrm_pkt_num, rd_addr, out_dval, out_data, scan_busy, scan_done, pkt_cnt, both errors. In-flight read tracking is cleared. Reset mid-scan aborts immediately; no partial word is emitted after reset.
- FSM states: IDLE, ARM, ARM_WAIT, HEAD, CHECK, STREAM, DRAIN, NEXT, DONE.
- IDLE:
  - chn_sel=0, hrm_pkt_num=0.
  - On scan_start: go to ARM, scan_busy=1, working packet counter cleared.
- ARM: chn_sel=1, hrm_pkt_num=0. Next cycle go to ARM_WAIT, which allows one cycle for the bank latch.
- HEAD:
  - rd_addr = slot base.
  - Wait RD_LAT cycles, then go to CHECK.
- CHECK, on the rd_data sample:
  - If bit17=1: the slot holds a packet. Emit the word (out_dval=1), set addr=base+1, go to STREAM.
  - Otherwise: the slot is empty, nothing is emitted, go to NEXT.
- STREAM:
  - Issue one address per cycle while out_afull=0. Stall issuing while out_afull=1; returning data is still emitted.
  - Each returned word is emitted the cycle it arrives.
  - On a returned word with bit16=1: stop issuing and go to DRAIN. Discard up to RD_LAT over-issued returns (no out_dval).
  - Issue is bounded at base+SLOT_WORDS-1.
  - If the word at offset SLOT_WORDS-1 returns without EOP: emit it with bit16 forced to 1, pulse len_err, go to DRAIN.
  - A returned word with bit17=1 after the first (nested SOP) is emitted unchanged; no check.
- DRAIN: wait until no reads are in flight, increment the packet counter, go to NEXT.
- NEXT:
  - If hrm_pkt_num==PKT_SLOTS-1, go to DONE.
  - Otherwise increment hrm_pkt_num and go to HEAD.
- DONE:
  - chn_sel=0, scan_done pulse.
  - pkt_cnt ← working counter.
  - scan_busy=0, back to IDLE.
- scan_start during any non-IDLE state: ignored, overrun_err pulses the same cycle.
- scan_start in the same cycle as DONE: treated as overrun.
- chn_sel is held low for at least one cycle between scans, so every scan presents a fresh rising edge.
- Address arithmetic is 9-bit. Slot base is computed from a 4-bit index and does not wrap, given the parameter constraint.
- Output latency: the first emitted word appears RD_LAT+1 cycles after HEAD entry.

Decomposition:
- Shared package (project DEFINES file) holds:
  - State encodings.
  - Bit positions SOP_BIT=17, EOP_BIT=16.
  - Default PKT_SLOTS, SLOT_WORDS, RD_LAT.
- One sub-module, hrm_rdlat_pipe: an RD_LAT-deep valid/discard shift register tracking in-flight reads and the drop-after-EOP flag.
- The FSM, address counter and output stage stay in the top.

Test Plan:
- Empty bank: slots 0..3 word0=18'h00000, scan_start → no out_dval, scan_done pulses, pkt_cnt=0, chn_sel high for exactly the scan duration.
- Single packet, slot 1: addr128=18'h2_0001, 129=18'h0_1234, 130=18'h1_ABCD → out_data sequence 2_0001, 0_1234, 1_ABCD, pkt_cnt=1, hrm_pkt_num reaches 3.
- Backpressure: 10-word packet in slot 0, out_afull=1 for 5 cycles after the third word → all 10 words in order, no duplicates or drops, no reads to addr ≥ base+10+RD_LAT.
- Missing EOP: slot 2 SOP with no EOP in 128 words → 128 words emitted, last with bit16=1, len_err pulse once, slot 3 still scanned.
- Overrun: scan_start again 5 cycles into a scan → overrun_err pulse, single scan_done, output identical to a non-overrun run.
- Reset mid-STREAM: rst_100m=1 for 1 cycle → next cycle all outputs 0, state IDLE, a following scan behaves normally.

Source files
------------

// File: rtl/hrm_mmrx_rdsched_pkg.sv
// Shared definitions for the MMRX read scheduler: state encoding, word-format
// bit positions and default geometry of the ping-pong read bank.
package hrm_mmrx_rdsched_pkg;

    localparam int SOP_BIT        = 17;
    localparam int EOP_BIT        = 16;
    localparam int DEF_PKT_SLOTS  = 4;
    localparam int DEF_SLOT_WORDS = 128;
    localparam int DEF_RD_LAT     = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARM,
        ST_ARM_WAIT,
        ST_HEAD,
        ST_CHECK,
        ST_STREAM,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } rd_state_t;

    // Slot k starts at k*words; the geometry keeps this inside 9 bits.
    function automatic logic [8:0] slot_base(input logic [3:0] idx, input int unsigned words);
        return 9'(32'(idx) * words);
    endfunction

endpackage

// File: rtl/hrm_mmrx_rdsched_if.sv
// Buffer-read and packet-FIFO signals of the read scheduler.
interface hrm_mmrx_rdsched_if;

    logic        chn_sel;
    logic [3:0]  hrm_pkt_num;
    logic [8:0]  rd_addr;
    logic [17:0] rd_data;
    logic        out_dval;
    logic [17:0] out_data;
    logic        out_afull;

    modport master (
        output chn_sel, hrm_pkt_num, rd_addr, out_dval, out_data,
        input  rd_data, out_afull
    );

    modport slave (
        input  chn_sel, hrm_pkt_num, rd_addr, out_dval, out_data,
        output rd_data, out_afull
    );

endinterface

// File: rtl/hrm_rdlat_pipe.sv
// Tracks reads in flight through the RD_LAT-deep buffer pipeline; reads caught
// by a flush (issued past EOP) still drain but return as discarded.
module hrm_rdlat_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic clk_100m,
    input  logic rst_100m,
    input  logic iss,
    input  logic flush,
    output logic ret_v,
    output logic busy
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] drop_q;

    always_ff @(posedge clk_100m) begin
        if (rst_100m) begin
            vld_q  <= '0;
            drop_q <= '0;
        end else begin
            vld_q[0]  <= iss;
            drop_q[0] <= flush;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                drop_q[i] <= drop_q[i-1] | flush;
            end
        end
    end

    assign ret_v = vld_q[RD_LAT-1] & ~drop_q[RD_LAT-1];
    assign busy  = iss | (|vld_q);

endmodule

// File: rtl/hrm_mmrx_rdsched.sv
// Read scheduler: opens the ping-pong read channel, walks every slot of the
// latched bank and streams each SOP..EOP packet into the MCU-side FIFO.
module hrm_mmrx_rdsched
    import hrm_mmrx_rdsched_pkg::*;
#(
    parameter int PKT_SLOTS  = DEF_PKT_SLOTS,
    parameter int SLOT_WORDS = DEF_SLOT_WORDS,
    parameter int RD_LAT     = DEF_RD_LAT
) (
    input  logic               clk_100m,
    input  logic               rst_100m,
    input  logic               scan_start,
    hrm_mmrx_rdsched_if.master bus,
    output logic               scan_busy,
    output logic               scan_done,
    output logic [4:0]         pkt_cnt,
    output logic               len_err,
    output logic               overrun_err
);

    // state     | meaning
    // IDLE      | channel closed, waiting for scan_start
    // ARM       | chn_sel rising edge at slot 0
    // ARM_WAIT  | one cycle for the buffer to latch the bank
    // HEAD      | slot base on rd_addr, waiting RD_LAT
    // CHECK     | word 0 returned: SOP opens a packet, else slot empty
    // STREAM    | issue/emit packet words until EOP or slot end
    // DRAIN     | let over-issued reads retire, count the packet
    // NEXT      | advance slot or finish
    // DONE      | close channel, publish pkt_cnt, pulse scan_done

    rd_state_t   state_q, state_d;
    logic [3:0]  num_q;
    logic [8:0]  addr_q;
    logic [8:0]  off_q;
    logic [3:0]  lat_q;
    logic [4:0]  work_q;
    logic        iss_q;
    logic        dval_q;
    logic [17:0] data_q;
    logic        len_err_q;
    logic [4:0]  pkt_cnt_q;

    logic        ret_v, inflight;
    logic [8:0]  base, last;
    logic        in_stream, ret_last, eop_hit, len_hit, can_issue, sop_hit;
    logic [17:0] ret_word;

    assign base      = slot_base(num_q, SLOT_WORDS);
    assign last      = base + 9'(SLOT_WORDS - 1);
    assign in_stream = (state_q == ST_STREAM);
    assign ret_last  = (off_q == 9'(SLOT_WORDS - 1));
    assign eop_hit   = in_stream && ret_v && (bus.rd_data[EOP_BIT] || ret_last);
    assign len_hit   = in_stream && ret_v && ret_last && !bus.rd_data[EOP_BIT];
    assign can_issue = in_stream && !eop_hit && !bus.out_afull && (addr_q != last);
    assign sop_hit   = (state_q == ST_CHECK) && bus.rd_data[SOP_BIT];

    always_comb begin
        ret_word = bus.rd_data;
        if (len_hit) ret_word[EOP_BIT] = 1'b1;
    end

    hrm_rdlat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
        .clk_100m (clk_100m),
        .rst_100m (rst_100m),
        .iss      (iss_q),
        .flush    (eop_hit),
        .ret_v    (ret_v),
        .busy     (inflight)
    );

    always_comb begin
        state_d     = state_q;
        scan_busy   = 1'b0;
        scan_done   = 1'b0;
        overrun_err = 1'b0;
        case (state_q)
            ST_IDLE:     if (scan_start) state_d = ST_ARM;
            ST_ARM:      state_d = ST_ARM_WAIT;
            ST_ARM_WAIT: state_d = ST_HEAD;
            ST_HEAD:     if (lat_q == 4'd0) state_d = ST_CHECK;
            ST_CHECK:    state_d = sop_hit ? ST_STREAM : ST_NEXT;
            ST_STREAM:   if (eop_hit) state_d = ST_DRAIN;
            ST_DRAIN:    if (!inflight) state_d = ST_NEXT;
            ST_NEXT:     state_d = (num_q == 4'(PKT_SLOTS - 1)) ? ST_DONE : ST_HEAD;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        scan_busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
        scan_done   = (state_q == ST_DONE);
        overrun_err = scan_start && (state_q != ST_IDLE);
    end

    always_ff @(posedge clk_100m) begin
        if (rst_100m) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            addr_q    <= '0;
            off_q     <= '0;
            lat_q     <= '0;
            work_q    <= '0;
            iss_q     <= 1'b0;
            dval_q    <= 1'b0;
            data_q    <= '0;
            len_err_q <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            iss_q     <= 1'b0;
            dval_q    <= 1'b0;
            len_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    num_q <= '0;
                    if (scan_start) work_q <= '0;
                end
                ST_ARM_WAIT: begin
                    addr_q <= base;
                    lat_q  <= 4'(RD_LAT - 1);
                end
                ST_HEAD: if (lat_q != 4'd0) lat_q <= lat_q - 4'd1;
                ST_CHECK: if (sop_hit) begin
                    dval_q <= 1'b1;
                    data_q <= bus.rd_data;
                    addr_q <= base + 9'd1;
                    iss_q  <= 1'b1;
                    off_q  <= 9'd1;
                end
                ST_STREAM: begin
                    if (ret_v) begin
                        dval_q    <= 1'b1;
                        data_q    <= ret_word;
                        off_q     <= off_q + 9'd1;
                        len_err_q <= len_hit;
                    end
                    if (can_issue) begin
                        addr_q <= addr_q + 9'd1;
                        iss_q  <= 1'b1;
                    end
                end
                ST_DRAIN: if (!inflight) work_q <= work_q + 5'd1;
                ST_NEXT: begin
                    if (num_q == 4'(PKT_SLOTS - 1)) begin
                        pkt_cnt_q <= work_q;
                    end else begin
                        num_q  <= num_q + 4'd1;
                        addr_q <= slot_base(num_q + 4'd1, SLOT_WORDS);
                        lat_q  <= 4'(RD_LAT - 1);
                    end
                end
                ST_DONE: begin
                    num_q  <= '0;
                    addr_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.chn_sel     = scan_busy;
    assign bus.hrm_pkt_num = num_q;
    assign bus.rd_addr     = addr_q;
    assign bus.out_dval    = dval_q;
    assign bus.out_data    = data_q;
    assign len_err         = len_err_q;
    assign pkt_cnt         = pkt_cnt_q;

endmodule

// File: tb/tb_hrm_mmrx_rdsched.sv
// Scoreboard bench for the MMRX read scheduler: a slot-walking reference model
// predicts each scan's packet words, a monitor checks what the DUT emits.
module tb_hrm_mmrx_rdsched;

    localparam int PKT_SLOTS  = 4;
    localparam int SLOT_WORDS = 128;
    localparam int RD_LAT     = 2;

    typedef struct {
        int pkts;
        int lens;
    } scan_exp_t;

    logic clk_100m = 1'b0;
    logic rst_100m = 1'b1;
    logic scan_start = 1'b0;
    logic scan_busy, scan_done, len_err, overrun_err;
    logic [4:0] pkt_cnt;

    hrm_mmrx_rdsched_if bif ();

    hrm_mmrx_rdsched #(
        .PKT_SLOTS  (PKT_SLOTS),
        .SLOT_WORDS (SLOT_WORDS),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk_100m    (clk_100m),
        .rst_100m    (rst_100m),
        .scan_start  (scan_start),
        .bus         (bif),
        .scan_busy   (scan_busy),
        .scan_done   (scan_done),
        .pkt_cnt     (pkt_cnt),
        .len_err     (len_err),
        .overrun_err (overrun_err)
    );

    always #5 clk_100m = ~clk_100m;

    // Buffer model: data for an address is valid RD_LAT cycles after it is presented.
    logic [17:0] mem [512];
    logic [8:0]  a_d [RD_LAT];
    always @(posedge clk_100m) begin
        a_d[0] <= bif.rd_addr;
        for (int i = 1; i < RD_LAT; i++) a_d[i] <= a_d[i-1];
    end
    assign bif.rd_data = mem[a_d[RD_LAT-1]];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk_100m) cyc <= cyc + 1;

    logic [17:0] exp_w[$];
    scan_exp_t   exp_scan[$];
    int lim [PKT_SLOTS];
    int exp_ovr = 0;

    bit mon_en = 0;
    int scan_words, len_seen, rises, max_num, viol, busy_mis;
    int done_cnt = 0;
    int ovr_seen = 0;
    int first_dval_cyc;
    bit chn_prev;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input longint act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected value %0h (cycle %0d)", nm, act, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a word or ends a scan.
    always @(negedge clk_100m) begin
        if (!mon_en) begin
            scan_words = 0; len_seen = 0; rises = 0; max_num = 0;
            viol = 0; busy_mis = 0; chn_prev = 0;
        end else begin
            if (bif.chn_sel && !chn_prev) begin
                rises++;
                chk("chn_rise_slot", bif.hrm_pkt_num, 0);
            end
            chn_prev = bif.chn_sel;
            if (bif.chn_sel !== scan_busy) busy_mis++;
            if (bif.chn_sel) begin
                int k, off;
                k = int'(bif.hrm_pkt_num);
                if (k > max_num) max_num = k;
                off = int'(bif.rd_addr) - k * SLOT_WORDS;
                if (k >= PKT_SLOTS || off < 0 || off >= lim[k]) viol++;
            end
            if (bif.out_dval) begin
                if (first_dval_cyc < 0) first_dval_cyc = cyc;
                if (exp_w.size() == 0) fail_now("out_extra_word", bif.out_data);
                else chk("out_data", bif.out_data, exp_w.pop_front());
                scan_words++;
            end
            if (len_err) len_seen++;
            if (overrun_err) ovr_seen++;
            if (scan_done) begin
                if (exp_scan.size() == 0) begin
                    fail_now("extra_scan_done", pkt_cnt);
                end else begin
                    scan_exp_t es;
                    es = exp_scan.pop_front();
                    chk("pkt_cnt", pkt_cnt, es.pkts);
                    chk("len_err_pulses", len_seen, es.lens);
                    chk("chn_sel_rises", rises, 1);
                    chk("last_slot", max_num, PKT_SLOTS - 1);
                    chk("rd_addr_bound", viol, 0);
                    chk("busy_vs_chn_sel", busy_mis, 0);
                    chk("words_missing", exp_w.size(), 0);
                    chk("chn_sel_at_done", bif.chn_sel, 0);
                end
                scan_words = 0; len_seen = 0; rises = 0; max_num = 0;
                viol = 0; busy_mis = 0;
                done_cnt++;
            end
        end
    end

    // Reference: walk the slots as the scheduler should and list emitted words.
    task automatic build_expect();
        scan_exp_t es;
        es.pkts = 0;
        es.lens = 0;
        for (int k = 0; k < PKT_SLOTS; k++) begin
            int base, len;
            logic [17:0] w;
            base = k * SLOT_WORDS;
            len  = 1;
            if (mem[base][17]) begin
                es.pkts++;
                exp_w.push_back(mem[base]);
                for (int off = 1; off < SLOT_WORDS; off++) begin
                    w = mem[base + off];
                    if (off == SLOT_WORDS - 1 && !w[16]) begin
                        w[16] = 1'b1;
                        es.lens++;
                    end
                    exp_w.push_back(w);
                    len++;
                    if (w[16]) break;
                end
            end
            lim[k] = (len + RD_LAT < SLOT_WORDS) ? len + RD_LAT : SLOT_WORDS;
        end
        exp_scan.push_back(es);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 18'h0;
    endtask

    // kind: 0 empty, 1 packet of len words, 2 SOP without any EOP
    task automatic fill_slot(input int k, input int kind, input int len);
        int base;
        base = k * SLOT_WORDS;
        for (int off = 0; off < SLOT_WORDS; off++) mem[base + off] = 18'($urandom);
        mem[base][17] = (kind != 0);
        if (kind == 1) begin
            for (int off = 1; off < len - 1; off++) mem[base + off][16] = 1'b0;
            if (len >= 2) mem[base + len - 1][16] = 1'b1;
        end else if (kind == 2) begin
            for (int off = 1; off < SLOT_WORDS; off++) mem[base + off][16] = 1'b0;
        end
    endtask

    task automatic rand_fill();
        for (int k = 0; k < PKT_SLOTS; k++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 5) fill_slot(k, 0, 0);
            else if (r == 5) fill_slot(k, 2, 0);
            else fill_slot(k, 1, int'($urandom_range(1, 24)));
        end
    endtask

    // bp_mode: 0 none, 1 random out_afull, 2 five-cycle stall after third word
    task automatic run_scan(input int bp_mode, input bit ovr, input bit lat_chk);
        int n, d0, bp_left, start_cyc;
        bit bp_fired;
        build_expect();
        first_dval_cyc = -1;
        d0 = done_cnt;
        @(posedge clk_100m); #1;
        scan_start = 1'b1;
        start_cyc  = cyc;
        @(posedge clk_100m); #1;
        scan_start = 1'b0;
        n = 0; bp_left = 0; bp_fired = 0;
        while (done_cnt == d0 && n < 5000) begin
            scan_start = ovr && (n == 4);
            if (ovr && n == 4) exp_ovr++;
            if (bp_mode == 1) begin
                bif.out_afull = ($urandom_range(0, 3) == 0);
            end else if (bp_mode == 2) begin
                if (!bp_fired && scan_words >= 3) begin
                    bp_left  = 5;
                    bp_fired = 1;
                end
                bif.out_afull = (bp_left > 0);
                if (bp_left > 0) bp_left--;
            end
            @(posedge clk_100m); #1;
            n++;
        end
        scan_start    = 1'b0;
        bif.out_afull = 1'b0;
        chk("scan_completed", done_cnt - d0, 1);
        if (lat_chk) chk("first_word_latency", first_dval_cyc - start_cyc, 4 + RD_LAT);
        repeat (2) @(posedge clk_100m);
        #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(nm, {bif.chn_sel, bif.hrm_pkt_num, bif.rd_addr, bif.out_dval, bif.out_data,
                 scan_busy, scan_done, pkt_cnt, len_err, overrun_err}, 0);
    endtask

    initial begin
        int ov0, dv, w;
        bif.out_afull = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk_100m);
        #1 rst_100m = 1'b0;
        check_reset_outputs("reset_outputs");
        mon_en = 1;

        // empty bank
        clear_mem();
        run_scan(0, 0, 0);

        // single packet in slot 1
        clear_mem();
        mem[128] = 18'h2_0001;
        mem[129] = 18'h0_1234;
        mem[130] = 18'h1_ABCD;
        run_scan(0, 0, 0);

        // 10-word packet in slot 0 with a stall after the third word
        clear_mem();
        mem[0] = 18'h2_0000;
        for (int i = 1; i < 9; i++) mem[i] = 18'(16'($urandom));
        mem[9] = 18'h1_0009;
        run_scan(2, 0, 1);

        // slot 2 never ends its packet, slot 3 must still be read
        clear_mem();
        fill_slot(2, 2, 0);
        fill_slot(3, 1, 5);
        run_scan(0, 0, 0);

        // second scan_start while busy
        rand_fill();
        fill_slot(0, 1, 8);
        ov0 = ovr_seen;
        run_scan(0, 1, 0);
        chk("overrun_pulses", ovr_seen - ov0, 1);

        // reset in the middle of streaming
        clear_mem();
        fill_slot(0, 1, 60);
        build_expect();
        @(posedge clk_100m); #1 scan_start = 1'b1;
        @(posedge clk_100m); #1 scan_start = 1'b0;
        w = 0;
        while (scan_words < 4 && w < 200) begin
            @(posedge clk_100m); #1;
            w++;
        end
        chk("reached_stream", scan_words >= 4, 1);
        rst_100m = 1'b1;
        mon_en   = 0;
        @(posedge clk_100m); #1;
        rst_100m = 1'b0;
        exp_w.delete();
        exp_scan.delete();
        check_reset_outputs("reset_mid_stream");
        dv = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_100m); #1;
            if (bif.out_dval || bif.chn_sel) dv++;
        end
        chk("quiet_after_reset", dv, 0);
        mon_en = 1;
        rand_fill();
        run_scan(0, 0, 0);

        // randomized banks with random backpressure
        for (int s = 0; s < 16; s++) begin
            rand_fill();
            run_scan((s % 3 == 0) ? 0 : 1, 0, 0);
        end

        chk("overrun_total", ovr_seen, exp_ovr);
        chk("scans_left", exp_scan.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
